// File: rtl/store_merge_unit.sv
// store_merge_unit
// Store-side byte-lane merge between the MEM-stage store request and a word-wide
// data memory. SB and SH stores read the addressed word, splice in the new byte or
// halfword, and write it back. SW stores write the word directly. Misaligned or
// illegal requests raise a one-cycle err pulse and write nothing.
//
// Ports
//   Clk          in   1       system clock, rising edge
//   Rst          in   1       asynchronous, active-low reset
//   req_valid    in   1       store request present
//   req_ready    out  1       unit idle; accepted when req_valid && req_ready
//   req_addr     in   32      byte address of the store
//   req_data     in   32      register value (low byte/halfword used for SB/SH)
//   req_size     in   2       00=SB, 01=SH, 10=SW, 11=illegal
//   mem_addr     out  ADDR_W  word address to data memory
//   mem_rd_en    out  1       one-cycle read strobe
//   mem_rd_data  in   32      read word, valid RD_LATENCY cycles after mem_rd_en
//   mem_wr_en    out  1       one-cycle write strobe
//   mem_wr_data  out  32      merged word to write
//   done         out  1       one-cycle pulse: store committed
//   err          out  1       one-cycle pulse: misaligned/illegal, nothing written
module store_merge_unit #(
    parameter int ADDR_W     = 30,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] SIZE_SB = 2'b00;
    localparam logic [1:0] SIZE_SH = 2'b01;
    localparam logic [1:0] SIZE_SW = 2'b10;

    // Value of the wait counter in the cycle where the read data is valid.
    localparam logic [2:0] LAST_WAIT = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic [2:0]  wait_cnt;
    logic        accept;
    logic        illegal;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    // Illegal size, odd halfword, or word not on a 4-byte boundary.
    assign illegal = (req_size == 2'b11) ||
                     ((req_size == SIZE_SH) && req_addr[0]) ||
                     ((req_size == SIZE_SW) && (req_addr[1:0] != 2'b00));

    // State register and latched request; reset abandons any store in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                size_q <= req_size;
            end
            if (state == READ) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if ((state == WAIT) && (wait_cnt == LAST_WAIT)) begin
                rdata_q <= mem_rd_data;
            end
        end
    end

    // Merge the new byte/halfword into the read word in its little-endian lane.
    always_comb begin
        merged = rdata_q;
        case (size_q)
            SIZE_SB: merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            SIZE_SH: merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merged = data_q;
        endcase
    end

    // Next-state and outputs; every output is zero outside the state that drives it.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal) begin
                        state_next = ERR;
                    end else if (req_size == SIZE_SW) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_rd_en  = 1'b1;
                mem_addr   = addr_q[ADDR_W+1:2];
                state_next = WAIT;
            end
            WAIT: begin
                mem_addr = addr_q[ADDR_W+1:2];
                if (wait_cnt == LAST_WAIT) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_addr    = addr_q[ADDR_W+1:2];
                mem_wr_en   = 1'b1;
                mem_wr_data = merged;
                done        = 1'b1;
                state_next  = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit
// Directed bench for store_merge_unit. Two instances share the request bus and a
// word memory model: dut1 uses RD_LATENCY=1, dut3 uses RD_LATENCY=3. Each memory
// port returns the addressed word exactly RD_LATENCY cycles after its read strobe
// and a poison value in every other cycle.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        valid1;
    logic        valid3;

    logic        ready1, rd_en1, wr_en1, done1, err1;
    logic [29:0] mem_addr1;
    logic [31:0] rd_data1, wr_data1;
    logic        ready3, rd_en3, wr_en3, done3, err3;
    logic [29:0] mem_addr3;
    logic [31:0] rd_data3, wr_data3;

    logic [31:0] mem [0:63];
    logic        p1_valid = 1'b0;
    logic [29:0] p1_addr = '0;
    logic [2:0]  p3_valid = 3'b000;
    logic [29:0] p3_addr [0:2];

    int          wr_count1 = 0;
    int          wr_count3 = 0;
    logic [29:0] log_addr [0:7];
    logic [31:0] log_data [0:7];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_reads;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_W(30), .RD_LATENCY(1)) dut1 (
        .Clk(clk), .Rst(rst_n), .req_valid(valid1), .req_ready(ready1),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr1), .mem_rd_en(rd_en1), .mem_rd_data(rd_data1),
        .mem_wr_en(wr_en1), .mem_wr_data(wr_data1), .done(done1), .err(err1)
    );

    store_merge_unit #(.ADDR_W(30), .RD_LATENCY(3)) dut3 (
        .Clk(clk), .Rst(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr3), .mem_rd_en(rd_en3), .mem_rd_data(rd_data3),
        .mem_wr_en(wr_en3), .mem_wr_data(wr_data3), .done(done3), .err(err3)
    );

    // Memory model: read pipelines, write port, and a log of dut1 writes.
    always @(posedge clk) begin
        p1_valid   <= rd_en1;
        p1_addr    <= mem_addr1;
        p3_valid   <= {p3_valid[1:0], rd_en3};
        p3_addr[0] <= mem_addr3;
        p3_addr[1] <= p3_addr[0];
        p3_addr[2] <= p3_addr[1];
        if (wr_en1) begin
            mem[mem_addr1[5:0]] <= wr_data1;
            if (wr_count1 < 8) begin
                log_addr[wr_count1] <= mem_addr1;
                log_data[wr_count1] <= wr_data1;
            end
            wr_count1 <= wr_count1 + 1;
        end
        if (wr_en3) begin
            mem[mem_addr3[5:0]] <= wr_data3;
            wr_count3 <= wr_count3 + 1;
        end
    end

    assign rd_data1 = p1_valid    ? mem[p1_addr[5:0]]    : 32'hBAAD_F00D;
    assign rd_data3 = p3_valid[2] ? mem[p3_addr[2][5:0]] : 32'hBAAD_F00D;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one request to dut1 and check the response and its timing.
    task automatic applyStimulus(input vec_t v);
        int   n;
        int   reads;
        logic seen;
        mem[v.addr[7:2]] = v.init;
        @(negedge clk);
        req_addr = v.addr;
        req_data = v.data;
        req_size = v.size;
        valid1   = 1'b1;
        checkOutput("ready_before", {31'b0, ready1}, 32'd1);
        @(negedge clk);
        valid1 = 1'b0;
        n      = 1;
        reads  = 0;
        seen   = 1'b0;
        while (!seen && n <= 20) begin
            if (rd_en1) reads++;
            if (rd_en1 && wr_en1) checkOutput("rd_wr_overlap", 32'd1, 32'd0);
            if (done1 || err1 || wr_en1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("latency", n, v.exp_lat);
        checkOutput("reads", reads, v.exp_reads);
        checkOutput("err", {31'b0, err1}, {31'b0, v.exp_err});
        checkOutput("done", {31'b0, done1}, {31'b0, !v.exp_err});
        checkOutput("wr_en", {31'b0, wr_en1}, {31'b0, !v.exp_err});
        if (!v.exp_err) begin
            checkOutput("wr_data", wr_data1, v.exp_data);
            checkOutput("wr_addr", {2'b0, mem_addr1}, {2'b0, v.addr[31:2]});
        end else begin
            checkOutput("err_wr_data", wr_data1, 32'd0);
        end
        @(negedge clk);
        checkOutput("ready_after", {31'b0, ready1}, 32'd1);
        checkOutput("idle_addr", {2'b0, mem_addr1}, 32'd0);
        checkOutput("idle_wr_data", wr_data1, 32'd0);
        if (!v.exp_err) checkOutput("mem_word", mem[v.addr[7:2]], v.exp_data);
    endtask

    initial begin
        int   n;
        int   reads;
        logic seen;
        int   w;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 3; i++) p3_addr[i] = '0;
        rst_n    = 1'b0;
        valid1   = 1'b0;
        valid3   = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_size = '0;

        vecs[0]  = '{2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0};
        vecs[1]  = '{2'b00, 32'h21, 32'h000000AB, 32'h11223344, 32'h1122AB44, 1'b0, 3, 1};
        vecs[2]  = '{2'b01, 32'h22, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 1'b0, 3, 1};
        vecs[3]  = '{2'b00, 32'h20, 32'hFFFFFF5A, 32'h11223344, 32'h1122335A, 1'b0, 3, 1};
        vecs[4]  = '{2'b00, 32'h23, 32'h00000077, 32'h11223344, 32'h77223344, 1'b0, 3, 1};
        vecs[5]  = '{2'b00, 32'h22, 32'h000000C3, 32'h11223344, 32'h11C33344, 1'b0, 3, 1};
        vecs[6]  = '{2'b01, 32'h20, 32'h12345678, 32'hAABBCCDD, 32'hAABB5678, 1'b0, 3, 1};
        vecs[7]  = '{2'b01, 32'h03, 32'h0000BEEF, 32'h55555555, 32'h0,        1'b1, 1, 0};
        vecs[8]  = '{2'b10, 32'h06, 32'h12345678, 32'h55555555, 32'h0,        1'b1, 1, 0};
        vecs[9]  = '{2'b11, 32'h00, 32'h12345678, 32'h55555555, 32'h0,        1'b1, 1, 0};
        vecs[10] = '{2'b01, 32'h01, 32'h0000BEEF, 32'h55555555, 32'h0,        1'b1, 1, 0};
        vecs[11] = '{2'b10, 32'h3C, 32'h01020304, 32'hFFFFFFFF, 32'h01020304, 1'b0, 1, 0};

        // Reset state
        #2;
        checkOutput("rst_ready1", {31'b0, ready1}, 32'd1);
        checkOutput("rst_ready3", {31'b0, ready3}, 32'd1);
        checkOutput("rst_strobes1", {28'b0, rd_en1, wr_en1, done1, err1}, 32'd0);
        checkOutput("rst_addr1", {2'b0, mem_addr1}, 32'd0);
        checkOutput("rst_wr_data1", wr_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // SH with RD_LATENCY=3 on dut3: done five cycles after acceptance
        mem[8] = 32'h11223344;
        @(negedge clk);
        req_addr = 32'h22;
        req_data = 32'h0000CAFE;
        req_size = 2'b01;
        valid3   = 1'b1;
        @(negedge clk);
        valid3 = 1'b0;
        n      = 1;
        reads  = 0;
        seen   = 1'b0;
        while (!seen && n <= 20) begin
            if (rd_en3) reads++;
            if (done3 || err3 || wr_en3) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("lat3_latency", n, 32'd5);
        checkOutput("lat3_reads", reads, 32'd1);
        checkOutput("lat3_wr_data", wr_data3, 32'hCAFE3344);
        checkOutput("lat3_wr_en", {31'b0, wr_en3}, 32'd1);
        @(negedge clk);
        checkOutput("lat3_ready_after", {31'b0, ready3}, 32'd1);

        // Back-to-back SW with req_valid held high
        w = wr_count1;
        req_addr = 32'h40;
        req_data = 32'hA1A2A3A4;
        req_size = 2'b10;
        valid1   = 1'b1;
        @(negedge clk);
        checkOutput("b2b_first_done", {31'b0, done1}, 32'd1);
        checkOutput("b2b_busy_ready", {31'b0, ready1}, 32'd0);
        req_addr = 32'h44;
        req_data = 32'hB1B2B3B4;
        @(negedge clk);
        checkOutput("b2b_ready_again", {31'b0, ready1}, 32'd1);
        @(negedge clk);
        valid1 = 1'b0;
        checkOutput("b2b_second_done", {31'b0, done1}, 32'd1);
        @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("b2b_write_count", wr_count1 - w, 32'd2);
        if (w < 7) begin
            checkOutput("b2b_addr0", {2'b0, log_addr[w]}, 32'h10);
            checkOutput("b2b_data0", log_data[w], 32'hA1A2A3A4);
            checkOutput("b2b_addr1", {2'b0, log_addr[w+1]}, 32'h11);
            checkOutput("b2b_data1", log_data[w+1], 32'hB1B2B3B4);
        end

        // Reset during WAIT of an SB on dut3
        mem[8] = 32'h11223344;
        @(negedge clk);
        req_addr = 32'h21;
        req_data = 32'h000000AB;
        req_size = 2'b00;
        valid3   = 1'b1;
        @(negedge clk);
        valid3 = 1'b0;
        checkOutput("rw_read_strobe", {31'b0, rd_en3}, 32'd1);
        @(negedge clk);
        checkOutput("rw_in_wait", {31'b0, ready3}, 32'd0);
        w = wr_count3;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rw_ready", {31'b0, ready3}, 32'd1);
        checkOutput("rw_strobes", {28'b0, rd_en3, wr_en3, done3, err3}, 32'd0);
        checkOutput("rw_addr", {2'b0, mem_addr3}, 32'd0);
        checkOutput("rw_wr_data", wr_data3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("rw_no_write", wr_count3 - w, 32'd0);
        checkOutput("rw_mem_intact", mem[8], 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
